// File: rtl/serial_frame_decoder_pkg.sv
// rtl/serial_frame_decoder_pkg.sv - shared frame length, FSM states and the four frame patterns
package serial_frame_decoder_pkg;

  localparam int FRAME_LEN = 100;
  localparam int CNT_W     = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SHIFT = 2'd2,
    ST_CHECK = 2'd3
  } fsm_state_e;

  localparam logic [FRAME_LEN-1:0] P1 =
    100'b0001010100000000001010001000000000000000010000000100000000000000000000000000000010100001010000001111;
  localparam logic [FRAME_LEN-1:0] P2 =
    100'b0000101010000000001010000100000000000000010000010001000000000000000000000000000000010101000000001111;
  localparam logic [FRAME_LEN-1:0] P3 =
    100'b0010000000101010100000010001010101010000000101010000101010000010101010101010101000000100000010100111;
  localparam logic [FRAME_LEN-1:0] P4 =
    100'b0010000000010101010000010001010101010000000010100010001010000010101010101010101010000000001010100111;

endpackage

// File: rtl/frame_pattern_match.sv
// rtl/frame_pattern_match.sv - combinational lookup of a captured frame against P1..P4
module frame_pattern_match
  import serial_frame_decoder_pkg::*;
(
  input  logic [FRAME_LEN-1:0] word,
  output logic                 hit,
  output logic                 polarity,
  output logic                 state
);

  // Patterns are mutually distinct, so the if-chain order carries no priority meaning.
  always_comb begin
    hit      = 1'b1;
    polarity = 1'b0;
    state    = 1'b0;
    if (word == P1) begin
      polarity = 1'b1;
      state    = 1'b1;
    end else if (word == P2) begin
      polarity = 1'b1;
      state    = 1'b0;
    end else if (word == P3) begin
      polarity = 1'b0;
      state    = 1'b1;
    end else if (word == P4) begin
      polarity = 1'b0;
      state    = 1'b0;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/serial_frame_decoder.sv
// rtl/serial_frame_decoder.sv - 100-bit MSB-first serial frame receiver and pattern decoder
// Optional feature: RX_SYNC_EN adds a two-flop rx synchronizer (+2 clocks latency).
module serial_frame_decoder
  import serial_frame_decoder_pkg::*;
#(
  parameter int IDLE_MIN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rx,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       polarity,
  output logic       state,
  output logic       busy,
  output logic [7:0] err_cnt
);

  localparam logic [4:0]       IDLE_MIN_C = 5'(IDLE_MIN);
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(FRAME_LEN);

  logic rx_s;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[0], rx};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= 2'b11;
    else      sync_q <= sync_d;
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  fsm_state_e           fsm_q, fsm_d;
  logic [3:0]           idle_cnt_q, idle_cnt_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [FRAME_LEN-1:0] shreg_q, shreg_d;
  logic                 frame_valid_q, frame_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 pol_q, pol_d;
  logic                 st_q, st_d;
  logic                 busy_q, busy_d;
  logic [7:0]           err_cnt_q, err_cnt_d;

  logic                 m_hit, m_pol, m_st;
  logic [4:0]           idle_inc;
  logic [CNT_W-1:0]     bit_inc;

  frame_pattern_match u_match (
    .word     (shreg_q),
    .hit      (m_hit),
    .polarity (m_pol),
    .state    (m_st)
  );

  always_comb begin
    fsm_d         = fsm_q;
    idle_cnt_d    = idle_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shreg_d       = shreg_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    pol_d         = pol_q;
    st_d          = st_q;
    err_cnt_d     = err_cnt_q;
    idle_inc      = {1'b0, idle_cnt_q} + 5'd1;
    bit_inc       = bit_cnt_q + 7'd1;

    if (!en) begin
      fsm_d      = ST_IDLE;
      idle_cnt_d = 4'd0;
      bit_cnt_d  = '0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (rx_s) begin
            idle_cnt_d = idle_inc[3:0];
            if (idle_inc >= IDLE_MIN_C) fsm_d = ST_ARMED;
          end else begin
            idle_cnt_d = 4'd0;
          end
        end
        ST_ARMED: begin
          if (!rx_s) begin
            shreg_d   = {shreg_q[FRAME_LEN-2:0], rx_s};
            bit_cnt_d = 7'd1;
            fsm_d     = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          shreg_d   = {shreg_q[FRAME_LEN-2:0], rx_s};
          bit_cnt_d = bit_inc;
          if (bit_inc == LAST_CNT) fsm_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (m_hit) begin
            frame_valid_d = 1'b1;
            pol_d         = m_pol;
            st_d          = m_st;
          end else begin
            frame_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
          bit_cnt_d = '0;
          // The sample taken in CHECK is the first idle bit; counting it lets a single
          // high separator arm the next frame when IDLE_MIN is 1.
          idle_cnt_d = {3'b000, rx_s};
          fsm_d      = (rx_s && (IDLE_MIN_C == 5'd1)) ? ST_ARMED : ST_IDLE;
        end
        default: fsm_d = ST_IDLE;
      endcase
    end

    busy_d = (fsm_d == ST_SHIFT) || (fsm_d == ST_CHECK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q         <= ST_IDLE;
      idle_cnt_q    <= 4'd0;
      bit_cnt_q     <= '0;
      shreg_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      pol_q         <= 1'b0;
      st_q          <= 1'b0;
      busy_q        <= 1'b0;
      err_cnt_q     <= 8'd0;
    end else begin
      fsm_q         <= fsm_d;
      idle_cnt_q    <= idle_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shreg_q       <= shreg_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      pol_q         <= pol_d;
      st_q          <= st_d;
      busy_q        <= busy_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign polarity    = pol_q;
  assign state       = st_q;
  assign busy        = busy_q;
  assign err_cnt     = err_cnt_q;

endmodule
